wb_write_queue: RTL and testbench
=================================

WB_WRITE_QUEUE -- requirements
Module: wb_write_queue

Interface
REQ-001: The module SHALL have parameter DEPTH, default 4, meaning the number of buffered register-write entries (power of two, 2..16).
REQ-002: The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003: The module SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004: The module SHALL have port in_valid, input, 1, meaning a write request is presented.
REQ-005: The module SHALL have port in_ready, output, 1, meaning the queue can accept the request.
REQ-006: The module SHALL have port in_reg, input, 5, the destination register number.
REQ-007: The module SHALL have port in_data, input, 64, the destination write value.
REQ-008: The module SHALL have port wr_hold, input, 1, meaning the register file write port is unavailable this cycle.
REQ-009: The module SHALL have port RegWrite, output, 1, the register file write enable.
REQ-010: The module SHALL have port WriteRegister, output, 5, the register file write address.
REQ-011: The module SHALL have port WriteData, output, 64, the register file write value.
REQ-012: The module SHALL have ports count (output, $clog2(DEPTH)+1, occupied entries), full (output, 1) and empty (output, 1).

Function
REQ-013: Handshake: a request SHALL be accepted on a rising edge where in_valid and in_ready are both 1; in_ready SHALL equal !full, independent of in_valid and wr_hold.
REQ-014: An accepted request with in_reg == 31 (XZR) SHALL complete the handshake but SHALL NOT be enqueued; count is unchanged by it.
REQ-015: Drain: RegWrite SHALL equal !empty && !wr_hold; WriteRegister and WriteData SHALL present the oldest entry when !empty and SHALL be 0 when empty.
REQ-016: The head entry SHALL be removed on each rising edge where RegWrite is 1; at most one entry drains per cycle, in strict acceptance order.
REQ-017: Latency: an entry accepted at edge N into an empty queue SHALL drive RegWrite=1 in the cycle following edge N (if wr_hold=0).
REQ-018: Simultaneous enqueue and drain SHALL leave count unchanged; enqueue only increments, drain only decrements.
REQ-019: Read and write pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-020: full SHALL be (count == DEPTH), empty SHALL be (count == 0); count SHALL never exceed DEPTH nor underflow.
REQ-021: When full, a drain edge SHALL free one entry, but in_ready SHALL remain 0 during that cycle (no same-cycle push-through).
REQ-022: wr_hold=1 SHALL freeze the head entry and outputs RegWrite=0; WriteRegister/WriteData still show the head.

Reset
REQ-023: reset=0 SHALL immediately clear pointers and count; outputs SHALL be RegWrite=0, WriteRegister=0, WriteData=0, count=0, empty=1, full=0, in_ready=1.
REQ-024: Reset asserted mid-operation SHALL discard all queued entries without issuing further writes; operation resumes on the first rising edge after reset deasserts.

Configuration
REQ-025: Macro WBQ_FWD_EN SHALL, when defined, add inputs ReadRegister1, ReadRegister2 (5 bits each) and outputs fwd_hit1, fwd_hit2 (1 bit) and fwd_data1, fwd_data2 (64 bits).
REQ-026: With WBQ_FWD_EN, fwd_hitN SHALL be 1 combinationally when any occupied entry (including the head draining this cycle) has reg == ReadRegisterN, and fwd_dataN SHALL be the youngest matching entry's data; otherwise fwd_hitN=0 and fwd_dataN=0.
REQ-027: With WBQ_FWD_EN, ReadRegisterN == 31 SHALL never hit.
REQ-028: Without WBQ_FWD_EN, the forwarding ports and match logic SHALL be absent; all other behaviour is identical.

Verification
REQ-029: Reset then push reg 5 / data 0x1234 with wr_hold=0 -> next cycle RegWrite=1, WriteRegister=5, WriteData=0x1234; following cycle empty=1, outputs 0.
REQ-030: wr_hold=1, push 4 entries (regs 1..4) -> full=1, in_ready=0, count=4; fifth push not accepted; release wr_hold -> writes regs 1,2,3,4 in four consecutive cycles.
REQ-031: Push reg 31 data 0xFFFF -> handshake completes, count stays 0, RegWrite never asserts.
REQ-032: Count=2, wr_hold=0, simultaneous push -> count stays 2; pointer wrap over 10 pushes preserves order.
REQ-033: (WBQ_FWD_EN) wr_hold=1, queue reg 7=0xA then reg 7=0xB, ReadRegister1=7, ReadRegister2=31 -> fwd_hit1=1, fwd_data1=0xB, fwd_hit2=0.
REQ-034: Queue 3 entries, assert reset=0 asynchronously mid-cycle -> RegWrite=0, count=0 immediately; no writes after deassertion.

Source files
------------

// File: rtl/wb_write_queue.sv
// Register-file write queue: buffers DEPTH register writes and drains them in order to the write port.
// Optional read-port forwarding from queued entries is enabled by defining WBQ_FWD_EN.
module wb_write_queue #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   // in_valid/in_ready: a request transfers on a rising edge where both are 1;
   // in_ready depends only on occupancy, never on in_valid or wr_hold.
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [4:0]               in_reg,
   input  logic [63:0]              in_data,
   input  logic                     wr_hold,
   output logic                     RegWrite,
   output logic [4:0]               WriteRegister,
   output logic [63:0]              WriteData,
`ifdef WBQ_FWD_EN
   input  logic [4:0]               ReadRegister1,
   input  logic [4:0]               ReadRegister2,
   output logic                     fwd_hit1,
   output logic                     fwd_hit2,
   output logic [63:0]              fwd_data1,
   output logic [63:0]              fwd_data2,
`endif
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [4:0]    mem_reg_q  [DEPTH];
   logic [4:0]    mem_reg_d  [DEPTH];
   logic [63:0]   mem_data_q [DEPTH];
   logic [63:0]   mem_data_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          push;
   logic          pop;

   assign full          = (count_q == CW'(DEPTH));
   assign empty         = (count_q == '0);
   assign count         = count_q;
   assign in_ready      = !full;
   assign RegWrite      = !empty && !wr_hold;
   assign WriteRegister = empty ? 5'd0  : mem_reg_q[rd_ptr_q];
   assign WriteData     = empty ? 64'd0 : mem_data_q[rd_ptr_q];

   // Writes to XZR complete the handshake but never occupy an entry.
   assign push = in_valid && in_ready && (in_reg != 5'd31);
   assign pop  = RegWrite;

   always_comb begin
      mem_reg_d  = mem_reg_q;
      mem_data_d = mem_data_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      if (push) begin
         mem_reg_d[wr_ptr_q]  = in_reg;
         mem_data_d[wr_ptr_q] = in_data;
         wr_ptr_d             = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_reg_q[i]  <= '0;
            mem_data_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_reg_q  <= mem_reg_d;
         mem_data_q <= mem_data_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

`ifdef WBQ_FWD_EN
   // Scan oldest to youngest so the last match seen is the youngest entry.
   always_comb begin
      logic [PW-1:0] idx;
      fwd_hit1  = 1'b0;
      fwd_hit2  = 1'b0;
      fwd_data1 = '0;
      fwd_data2 = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = rd_ptr_q + PW'(i);
         if (CW'(i) < count_q) begin
            if ((ReadRegister1 != 5'd31) && (mem_reg_q[idx] == ReadRegister1)) begin
               fwd_hit1  = 1'b1;
               fwd_data1 = mem_data_q[idx];
            end
            if ((ReadRegister2 != 5'd31) && (mem_reg_q[idx] == ReadRegister2)) begin
               fwd_hit2  = 1'b1;
               fwd_data2 = mem_data_q[idx];
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed bench for wb_write_queue: reset, latency, full/hold, XZR, simultaneous push/pop, wrap, async reset.
// Forwarding scenario is built only when WBQ_FWD_EN is defined.
module tb_wb_write_queue;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_reg;
   logic [63:0] in_data;
   logic        wr_hold;
   logic        RegWrite;
   logic [4:0]  WriteRegister;
   logic [63:0] WriteData;
   logic [2:0]  count;
   logic        full;
   logic        empty;
`ifdef WBQ_FWD_EN
   logic [4:0]  ReadRegister1;
   logic [4:0]  ReadRegister2;
   logic        fwd_hit1;
   logic        fwd_hit2;
   logic [63:0] fwd_data1;
   logic [63:0] fwd_data2;
`endif

   int checks   = 0;
   int failures = 0;

   wb_write_queue #(.DEPTH(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_reg        (in_reg),
      .in_data       (in_data),
      .wr_hold       (wr_hold),
      .RegWrite      (RegWrite),
      .WriteRegister (WriteRegister),
      .WriteData     (WriteData),
`ifdef WBQ_FWD_EN
      .ReadRegister1 (ReadRegister1),
      .ReadRegister2 (ReadRegister2),
      .fwd_hit1      (fwd_hit1),
      .fwd_hit2      (fwd_hit2),
      .fwd_data1     (fwd_data1),
      .fwd_data2     (fwd_data2),
`endif
      .count         (count),
      .full          (full),
      .empty         (empty)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_one(input logic [4:0] r, input logic [63:0] d);
      in_valid = 1'b1;
      in_reg   = r;
      in_data  = d;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #12;
      checks++; if (RegWrite !== 1'b0) begin failures++; $display("FAIL reset_regwrite got=%0b exp=0", RegWrite); end
      checks++; if (WriteRegister !== 5'd0) begin failures++; $display("FAIL reset_wreg got=%0d exp=0", WriteRegister); end
      checks++; if (WriteData !== 64'd0) begin failures++; $display("FAIL reset_wdata got=%0h exp=0", WriteData); end
      checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
      checks++; if (empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL reset_flags got=%0b%0b exp=10", empty, full); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
      tick();
      reset = 1'b1;
      tick();
   endtask

   task automatic test_single_write();
      wr_hold = 1'b0;
      push_one(5'd5, 64'h1234);
      checks++; if (RegWrite !== 1'b1) begin failures++; $display("FAIL single_regwrite got=%0b exp=1", RegWrite); end
      checks++; if (WriteRegister !== 5'd5) begin failures++; $display("FAIL single_wreg got=%0d exp=5", WriteRegister); end
      checks++; if (WriteData !== 64'h1234) begin failures++; $display("FAIL single_wdata got=%0h exp=1234", WriteData); end
      checks++; if (count !== 3'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", count); end
      tick();
      checks++; if (empty !== 1'b1 || RegWrite !== 1'b0) begin failures++; $display("FAIL single_drained got=empty%0b/rw%0b exp=empty1/rw0", empty, RegWrite); end
      checks++; if (WriteRegister !== 5'd0 || WriteData !== 64'd0) begin failures++; $display("FAIL single_zero_out got=%0d/%0h exp=0/0", WriteRegister, WriteData); end
   endtask

   task automatic test_full_hold();
      wr_hold = 1'b1;
      for (int i = 1; i <= 4; i++) push_one(5'(i), 64'(100 + i));
      checks++; if (full !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL full_flags got=full%0b/rdy%0b exp=full1/rdy0", full, in_ready); end
      checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", count); end
      checks++; if (RegWrite !== 1'b0 || WriteRegister !== 5'd1) begin failures++; $display("FAIL full_hold_head got=rw%0b/reg%0d exp=rw0/reg1", RegWrite, WriteRegister); end
      push_one(5'd9, 64'd999);
      checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_fifth_push got=%0d exp=4", count); end
      wr_hold = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         // offer a request while full and draining: must not push through
         in_valid = (i == 1);
         in_reg   = 5'd9;
         in_data  = 64'd999;
         #1;
         if (i == 1) begin
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_no_pushthrough got=%0b exp=0", in_ready); end
         end
         checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'(i) || WriteData !== 64'(100 + i)) begin
            failures++; $display("FAIL full_drain_%0d got=rw%0b/reg%0d/data%0d exp=rw1/reg%0d/data%0d", i, RegWrite, WriteRegister, WriteData, i, 100 + i);
         end
         tick();
         in_valid = 1'b0;
      end
      checks++; if (empty !== 1'b1 || RegWrite !== 1'b0) begin failures++; $display("FAIL full_drain_end got=empty%0b/rw%0b exp=empty1/rw0", empty, RegWrite); end
   endtask

   task automatic test_xzr();
      wr_hold  = 1'b0;
      in_valid = 1'b1;
      in_reg   = 5'd31;
      in_data  = 64'hFFFF;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL xzr_ready got=%0b exp=1", in_ready); end
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++; if (RegWrite !== 1'b0 || count !== 3'd0) begin failures++; $display("FAIL xzr_no_write_%0d got=rw%0b/cnt%0d exp=rw0/cnt0", i, RegWrite, count); end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      wr_hold = 1'b1;
      push_one(5'd10, 64'hA10);
      push_one(5'd11, 64'hA11);
      wr_hold  = 1'b0;
      in_valid = 1'b1;
      in_reg   = 5'd12;
      in_data  = 64'hA12;
      #1;
      checks++; if (count !== 3'd2 || RegWrite !== 1'b1 || WriteRegister !== 5'd10) begin failures++; $display("FAIL b2b_pre got=cnt%0d/rw%0b/reg%0d exp=cnt2/rw1/reg10", count, RegWrite, WriteRegister); end
      tick();
      in_valid = 1'b0;
      checks++; if (count !== 3'd2 || WriteRegister !== 5'd11) begin failures++; $display("FAIL b2b_same_count got=cnt%0d/reg%0d exp=cnt2/reg11", count, WriteRegister); end
      tick();
      checks++; if (WriteRegister !== 5'd12 || WriteData !== 64'hA12) begin failures++; $display("FAIL b2b_tail got=%0d/%0h exp=12/a12", WriteRegister, WriteData); end
      tick();
      checks++; if (empty !== 1'b1) begin failures++; $display("FAIL b2b_empty got=%0b exp=1", empty); end
   endtask

   task automatic test_wrap();
      logic [68:0] exp_q[$];
      int          pushed = 0;
      int          cyc    = 0;
      logic        exp_rw;
      logic        exp_rdy;
      while ((pushed < 10 || exp_q.size() != 0) && cyc < 100) begin
         wr_hold  = (cyc < 6) ? 1'b1 : (cyc % 3 == 0);
         in_valid = (pushed < 10);
         in_reg   = 5'(pushed + 1);
         in_data  = 64'hD000 + 64'(pushed);
         #1;
         exp_rw  = (exp_q.size() != 0) && !wr_hold;
         exp_rdy = (exp_q.size() < 4);
         checks++; if (in_ready !== exp_rdy) begin failures++; $display("FAIL wrap_ready c%0d got=%0b exp=%0b", cyc, in_ready, exp_rdy); end
         checks++; if (RegWrite !== exp_rw) begin failures++; $display("FAIL wrap_regwrite c%0d got=%0b exp=%0b", cyc, RegWrite, exp_rw); end
         checks++; if (count !== 3'(exp_q.size())) begin failures++; $display("FAIL wrap_count c%0d got=%0d exp=%0d", cyc, count, exp_q.size()); end
         if (exp_rw) begin
            checks++; if ({WriteRegister, WriteData} !== exp_q[0]) begin failures++; $display("FAIL wrap_order c%0d got=%0d/%0h exp=%0d/%0h", cyc, WriteRegister, WriteData, exp_q[0][68:64], exp_q[0][63:0]); end
         end
         tick();
         if (exp_rw) void'(exp_q.pop_front());
         if (in_valid && exp_rdy) begin
            exp_q.push_back({in_reg, in_data});
            pushed++;
         end
         cyc++;
      end
      in_valid = 1'b0;
      wr_hold  = 1'b0;
      checks++; if (cyc >= 100) begin failures++; $display("FAIL wrap_timeout got=%0d cycles exp=<100", cyc); end
      checks++; if (empty !== 1'b1) begin failures++; $display("FAIL wrap_end_empty got=%0b exp=1", empty); end
   endtask

   task automatic test_async_reset();
      wr_hold = 1'b1;
      for (int i = 1; i <= 3; i++) push_one(5'(20 + i), 64'(i));
      wr_hold = 1'b0;
      #1;
      checks++; if (RegWrite !== 1'b1 || count !== 3'd3) begin failures++; $display("FAIL areset_pre got=rw%0b/cnt%0d exp=rw1/cnt3", RegWrite, count); end
      #2;
      reset = 1'b0;
      #1;
      checks++; if (RegWrite !== 1'b0 || count !== 3'd0 || empty !== 1'b1) begin failures++; $display("FAIL areset_now got=rw%0b/cnt%0d/empty%0b exp=rw0/cnt0/empty1", RegWrite, count, empty); end
      tick();
      tick();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (RegWrite !== 1'b0 || count !== 3'd0) begin failures++; $display("FAIL areset_after_%0d got=rw%0b/cnt%0d exp=rw0/cnt0", i, RegWrite, count); end
      end
      push_one(5'd2, 64'h55);
      checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd2 || WriteData !== 64'h55) begin failures++; $display("FAIL areset_resume got=rw%0b/reg%0d/%0h exp=rw1/reg2/55", RegWrite, WriteRegister, WriteData); end
      tick();
   endtask

`ifdef WBQ_FWD_EN
   task automatic test_fwd();
      wr_hold = 1'b1;
      push_one(5'd7, 64'hA);
      push_one(5'd7, 64'hB);
      push_one(5'd3, 64'hC);
      ReadRegister1 = 5'd7;
      ReadRegister2 = 5'd31;
      #1;
      checks++; if (fwd_hit1 !== 1'b1 || fwd_data1 !== 64'hB) begin failures++; $display("FAIL fwd_youngest got=%0b/%0h exp=1/b", fwd_hit1, fwd_data1); end
      checks++; if (fwd_hit2 !== 1'b0 || fwd_data2 !== 64'd0) begin failures++; $display("FAIL fwd_xzr got=%0b/%0h exp=0/0", fwd_hit2, fwd_data2); end
      ReadRegister1 = 5'd9;
      ReadRegister2 = 5'd3;
      #1;
      checks++; if (fwd_hit1 !== 1'b0 || fwd_data1 !== 64'd0) begin failures++; $display("FAIL fwd_miss got=%0b/%0h exp=0/0", fwd_hit1, fwd_data1); end
      checks++; if (fwd_hit2 !== 1'b1 || fwd_data2 !== 64'hC) begin failures++; $display("FAIL fwd_hit2 got=%0b/%0h exp=1/c", fwd_hit2, fwd_data2); end
      wr_hold = 1'b0;
      tick();
      tick();
      tick();
      ReadRegister2 = 5'd3;
      #1;
      checks++; if (fwd_hit2 !== 1'b0) begin failures++; $display("FAIL fwd_after_drain got=%0b exp=0", fwd_hit2); end
   endtask
`endif

   initial begin
      in_valid = 1'b0;
      in_reg   = '0;
      in_data  = '0;
      wr_hold  = 1'b0;
`ifdef WBQ_FWD_EN
      ReadRegister1 = '0;
      ReadRegister2 = '0;
`endif
      test_reset();
      test_single_write();
      test_full_hold();
      test_xzr();
      test_back_to_back();
      test_wrap();
      test_async_reset();
`ifdef WBQ_FWD_EN
      test_fwd();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
